aoc_line_parser: RTL

- Upstream neighbour of the dial-rotation coprocessor: converts the UART RX ASCII byte stream (lines such as "L68" or "R48", ended by LF) into one signed rotation delta per line.
- Emits each delta sign-extended to the coprocessor's din width with a single-cycle valid pulse.
- Also exposes a sticky error flag and a count of emitted lines for debug readback.

---
 rtl/aoc_parse_pkg.sv | 45 ++++
 rtl/aoc_line_parser_dec_accum.sv | 62 ++++++
 rtl/aoc_line_parser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/aoc_parse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aoc_parse_pkg
// Description : Shared constants for the AoC line parser. Holds the ASCII
//               characters the parser recognises, the 2-bit parser state
//               encoding, the default datapath widths and two small helpers
//               for classifying and decoding decimal digit bytes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aoc_parse_pkg;

  // Default widths, used as parameter defaults by the parser blocks
  localparam int DEF_WIDTH_DOUT    = 128;
  localparam int DEF_WIDTH_COMPUTE = 32;
  localparam int DEF_MAX_DIGITS    = 9;

  // ASCII characters of interest
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  // Parser state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;

  // True when the byte is an ASCII decimal digit
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  // Numeric value of a digit byte; only meaningful when is_digit(b) holds
  function automatic logic [3:0] digit_val(input logic [7:0] b);
    logic [7:0] diff;
    diff = b - CH_0;
    return diff[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aoc_line_parser_dec_accum.sv
`default_nettype none
// ============================================================================
// Module      : dec_accum
// Description : Decimal accumulator for the line parser. Builds an unsigned
//               value from a stream of decimal digits (most significant
//               first) and counts how many digits were taken.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-low reset
//               clear        - zero the value and digit count
//               digit_strobe - accept 'digit' this cycle
//               digit        - digit value 0..9
//               acc          - accumulated unsigned value
//               full         - MAX_DIGITS digits already taken
//               has_digit    - at least one digit taken since clear
// Revision    : 1.0 - initial release
// ============================================================================
module dec_accum
  import aoc_parse_pkg::*;
#(
  parameter int WIDTH_COMPUTE = DEF_WIDTH_COMPUTE,
  parameter int MAX_DIGITS    = DEF_MAX_DIGITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     digit_strobe,
  input  logic [3:0]               digit,
  output logic [WIDTH_COMPUTE-1:0] acc,
  output logic                     full,
  output logic                     has_digit
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [CNT_W-1:0]         r_digit_cnt;
  logic [WIDTH_COMPUTE-1:0] r_acc;
  logic [WIDTH_COMPUTE-1:0] w_acc_next;

  // acc*10 + digit, with the multiply expressed as (acc<<3) + (acc<<1)
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + WIDTH_COMPUTE'(digit);

  assign full      = (r_digit_cnt == CNT_W'(MAX_DIGITS));
  assign has_digit = (r_digit_cnt != '0);
  assign acc       = r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_digit_cnt <= '0;
    end else if (clear) begin
      r_acc       <= '0;
      r_digit_cnt <= '0;
    end else if (digit_strobe && !full) begin
      // The full guard keeps the count from wrapping even if the caller
      // strobes a digit it should have rejected.
      r_acc       <= w_acc_next;
      r_digit_cnt <= r_digit_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/aoc_line_parser.sv
`default_nettype none
// ============================================================================
// Module      : aoc_line_parser
// Description : Converts a UART ASCII byte stream of lines like "L68\n" or
//               "R48\r\n" into one signed rotation delta per line, sign-
//               extended to the coprocessor input width, with a one-cycle
//               valid pulse. Malformed lines raise a sticky error and are
//               skipped up to the next LF.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               rx_data    - received ASCII byte
//               rx_valid   - rx_data carries a byte this cycle
//               dout       - signed delta, sign-extended, held between lines
//               dout_valid - one-cycle pulse marking a new dout
//               err        - sticky malformed-line flag
//               err_clear  - synchronous clear for err (a new error wins)
//               line_count - number of deltas emitted, wraps mod 2^32
//               busy       - parser is inside a line
// Revision    : 1.0 - initial release
// ============================================================================
module aoc_line_parser
  import aoc_parse_pkg::*;
#(
  parameter int WIDTH_DOUT    = DEF_WIDTH_DOUT,
  parameter int WIDTH_COMPUTE = DEF_WIDTH_COMPUTE,
  parameter int MAX_DIGITS    = DEF_MAX_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [WIDTH_DOUT-1:0] dout,
  output logic                  dout_valid,
  output logic                  err,
  input  logic                  err_clear,
  output logic [31:0]           line_count,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic                  r_dir;        // 1 = negative ('L')
  logic [WIDTH_DOUT-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_err;
  logic [31:0]           r_line_count;

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  logic [1:0] w_next_state;
  logic       w_next_dir;
  logic       w_clear_acc;
  logic       w_digit_strobe;
  logic       w_set_err;
  logic       w_emit;

  // Byte classification
  logic       w_is_digit;
  logic [3:0] w_digit;

  // Accumulator interface
  logic [WIDTH_COMPUTE-1:0] w_acc;
  logic                     w_full;
  logic                     w_has_digit;

  // Signed result
  logic [WIDTH_COMPUTE-1:0] w_delta;
  logic [WIDTH_DOUT-1:0]    w_delta_ext;

  assign w_is_digit = is_digit(rx_data);
  assign w_digit    = digit_val(rx_data);

  always_comb begin
    w_next_state   = r_state;
    w_next_dir     = r_dir;
    w_clear_acc    = 1'b0;
    w_digit_strobe = 1'b0;
    w_set_err      = 1'b0;
    w_emit         = 1'b0;

    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == CH_L || rx_data == CH_R) begin
            w_next_dir   = (rx_data == CH_L);
            w_clear_acc  = 1'b1;
            w_next_state = S_NUM;
          end else if (rx_data == CH_CR || rx_data == CH_LF || rx_data == CH_SP) begin
            // Whitespace and blank lines between commands are legal
            w_next_state = S_IDLE;
          end else begin
            w_set_err    = 1'b1;
            w_next_state = S_SKIP;
          end
        end

        S_NUM: begin
          if (w_is_digit) begin
            if (w_full) begin
              // Too many digits: the value could overflow, so drop the line
              w_set_err    = 1'b1;
              w_next_state = S_SKIP;
            end else begin
              w_digit_strobe = 1'b1;
            end
          end else if (rx_data == CH_CR) begin
            w_next_state = S_NUM;
          end else if (rx_data == CH_LF) begin
            if (w_has_digit) begin
              w_emit = 1'b1;
            end else begin
              // Direction letter with no magnitude; LF already ends the line
              w_set_err = 1'b1;
            end
            w_next_state = S_IDLE;
          end else begin
            w_set_err    = 1'b1;
            w_next_state = S_SKIP;
          end
        end

        S_SKIP: begin
          if (rx_data == CH_LF) begin
            w_next_state = S_IDLE;
          end
        end

        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Decimal accumulator
  // --------------------------------------------------------------------------
  dec_accum #(
    .WIDTH_COMPUTE (WIDTH_COMPUTE),
    .MAX_DIGITS    (MAX_DIGITS)
  ) u_dec_accum (
    .clk          (clk),
    .rst          (rst),
    .clear        (w_clear_acc),
    .digit_strobe (w_digit_strobe),
    .digit        (w_digit),
    .acc          (w_acc),
    .full         (w_full),
    .has_digit    (w_has_digit)
  );

  // --------------------------------------------------------------------------
  // Sign application. Negating zero yields zero, so "L0" emits plain 0.
  // --------------------------------------------------------------------------
  assign w_delta     = r_dir ? (~w_acc + WIDTH_COMPUTE'(1)) : w_acc;
  assign w_delta_ext = WIDTH_DOUT'($signed(w_delta));

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_dir        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_dir        <= w_next_dir;
      r_dout_valid <= w_emit;

      if (w_emit) begin
        r_dout       <= w_delta_ext;
        r_line_count <= r_line_count + 32'd1;
      end

      // A new error in the same cycle as err_clear keeps the flag set
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (err_clear) begin
        r_err <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign err        = r_err;
  assign line_count = r_line_count;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
